coincidence_counter: RTL and testbench
======================================

Name: coincidence_counter

Overview:
Pairwise coincidence counter for NCHAN detector channels. Each channel has a programmable delay and a programmable coincidence window. All channel pairs are counted over a gated acquisition period of fixed length. Results are latched into a snapshot and offered on a valid/ready readout handshake, so the next acquisition can be armed after readout.

Parameters:
NCHAN, 4, number of input channels (>=2); NPAIR = NCHAN*(NCHAN-1)/2 is derived
DBITS, 4, delay select width; per-channel delay range 0..2^DBITS-1 cycles
WBITS, 3, coincidence window width; window range 0..2^WBITS-1 cycles
CBITS, 16, width of each pair counter
PBITS, 24, acquisition gate length width

Ports:
Clk  in  1  clock
Rst_n  in  1  asynchronous, active-low reset
Channels  in  NCHAN  detector levels, already synchronous to Clk
Delays  in  NCHAN*DBITS  delay of channel i in bits [i*DBITS +: DBITS]
Window  in  WBITS  coincidence window in cycles
Gate_len  in  PBITS  acquisition length in cycles
Start  in  1  arm acquisition; honoured only in IDLE
Abort  in  1  cancel an acquisition in progress
Busy  out  1  state != IDLE
Valid  out  1  snapshot available
Ready  in  1  consumer accepts snapshot
Counts  out  NPAIR*CBITS  pair k count in bits [k*CBITS +: CBITS]
Ovf  out  NPAIR  sticky saturation flag per pair

Behaviour:
- Reset: state IDLE. Busy=0, Valid=0, Counts=0, Ovf=0. Edge-detect history, delay lines, window counters and working counters are all cleared.
- Pair order: k enumerates (i<j) lexicographically: (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1).
- Edge detect: p[i] = Channels[i] & ~prev[i]. prev is registered, so one pulse per rising level.
- Delay: d[i] = p[i] delayed by exactly Delays_r[i] cycles, using a 2^DBITS-1 stage shift register with a mux tap. Delay 0 passes p[i] combinationally.
- Window: on d[i], win[i] loads Window_r. Otherwise win[i] decrements while nonzero.
  - open[i] = d[i] | (win[i]!=0).
  - Window_r=0 means same-cycle coincidence only.
- Coincidence for pair (i,j) in a cycle: (d[i]&open[j]) | (d[j]&open[i]). This is at most +1 per pair per cycle.
- Delays_r, Window_r: captured at an accepted Start and held for the whole acquisition. The delay and window logic runs continuously in all states.
- FSM:
  - IDLE: Start=1 and Gate_len!=0 -> clear working counters and Ovf, load gate=Gate_len, go ACQ. Start with Gate_len=0 is ignored.
  - ACQ: counting is enabled. gate decrements each cycle, giving exactly Gate_len enabled cycles starting the cycle after Start.
    - At the last enabled cycle, go HOLD. The snapshot Counts/Ovf is latched including that cycle's increments.
    - Abort=1 -> IDLE with no snapshot; Counts/Ovf keep their previous values. Abort outranks gate expiry.
  - HOLD: Valid=1, asserted on cycle Start+Gate_len+1. Counts and Ovf are stable while Valid. Valid&Ready -> IDLE, Valid=0 next cycle. Abort is ignored in HOLD. Start is ignored unless in IDLE.
- Saturation: each pair counter stops at 2^CBITS-1. An increment attempted at saturation sets Ovf[k].
- Pulses in the Start cycle are not counted. Pulses whose window straddles ACQ entry are counted if the triggering d[] occurs in an enabled cycle.
- Reset mid-operation: immediate return to reset state. Any pending snapshot is lost.

Test Plan:
- NCHAN=4, Delays=0, Window=0, Gate_len=100: single rising edges on ch0 and ch1 in the same cycle, 5 times -> Counts pair0=5, all others 0; Valid at Start+101.
- Ch0 edge at t, ch2 edge at t+3, Window=3 -> pair(0,2)=1. Repeat with Window=2 -> pair(0,2)=0.
- Ch1 edge at t, ch3 edge at t+4, Delays[1]=4, Window=0 -> pair(1,3)=1. Delays[1]=3 -> 0.
- CBITS=4, 20 coincidences on (0,1) -> Counts pair0=15, Ovf[0]=1, other Ovf bits 0.
- Abort in ACQ cycle 10 -> IDLE, Valid stays 0, Counts unchanged. Start with Gate_len=0 -> Busy stays 0.
- Valid held with Ready=0 for 50 cycles while channels toggle -> Counts stable and Start ignored. Ready=1 -> Valid drops next cycle, Busy=0. Rst_n low during ACQ -> all outputs 0.

Source files
------------

// File: rtl/coincidence_counter.sv
// Pairwise coincidence counter: edge detect, per-channel delay and window, gated pair counting into a snapshot.
// Snapshot valid Gate_len+1 cycles after Start; Valid is held with stable Counts/Ovf until Ready.
module coincidence_counter #(
    parameter int NCHAN = 4,
    parameter int DBITS = 4,
    parameter int WBITS = 3,
    parameter int CBITS = 16,
    parameter int PBITS = 24
) (
    input  logic                                 Clk,
    input  logic                                 Rst_n,
    input  logic [NCHAN-1:0]                     Channels,
    input  logic [NCHAN*DBITS-1:0]               Delays,
    input  logic [WBITS-1:0]                     Window,
    input  logic [PBITS-1:0]                     Gate_len,
    input  logic                                 Start,
    input  logic                                 Abort,
    output logic                                 Busy,
    output logic                                 Valid,
    input  logic                                 Ready,
    output logic [NCHAN*(NCHAN-1)/2*CBITS-1:0]   Counts,
    output logic [NCHAN*(NCHAN-1)/2-1:0]         Ovf
);

    localparam int NPAIR = NCHAN * (NCHAN - 1) / 2;
    localparam int LEN   = (1 << DBITS) - 1;
    localparam logic [CBITS-1:0] CMAX = {CBITS{1'b1}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]                   state_q, state_d;
    logic [PBITS-1:0]             gate_q, gate_d;
    logic [NCHAN*DBITS-1:0]       dly_q, dly_d;
    logic [WBITS-1:0]             wcfg_q, wcfg_d;
    logic [NPAIR-1:0][CBITS-1:0]  cnt_q, cnt_d;
    logic [NPAIR-1:0]             wovf_q, wovf_d;
    logic [NPAIR-1:0][CBITS-1:0]  counts_q, counts_d;
    logic [NPAIR-1:0]             ovf_q, ovf_d;

    logic [NCHAN-1:0]             prev_q;
    logic [LEN-1:0]               sr_q [NCHAN];
    logic [LEN-1:0]               sr_d [NCHAN];
    logic [WBITS-1:0]             win_q [NCHAN];
    logic [WBITS-1:0]             win_d [NCHAN];

    logic [NCHAN-1:0]             p;
    logic [NCHAN-1:0]             d;
    logic [NCHAN-1:0]             open;
    logic [NPAIR-1:0]             hit;

    assign p = Channels & ~prev_q;

    // Tap 0 is the undelayed pulse, tap n is the shift stage n cycles back.
    for (genvar i = 0; i < NCHAN; i++) begin : g_ch
        logic [LEN:0] taps;
        assign taps     = {sr_q[i], p[i]};
        assign d[i]     = taps[dly_q[i*DBITS +: DBITS]];
        assign sr_d[i]  = taps[LEN-1:0];
        assign open[i]  = d[i] | (win_q[i] != '0);
        assign win_d[i] = d[i] ? wcfg_q :
                          (win_q[i] != '0) ? win_q[i] - WBITS'(1) : win_q[i];
    end

    for (genvar i = 0; i < NCHAN - 1; i++) begin : g_pi
        for (genvar j = i + 1; j < NCHAN; j++) begin : g_pj
            localparam int K = i * NCHAN - (i * (i + 1)) / 2 + (j - i - 1);
            assign hit[K] = (d[i] & open[j]) | (d[j] & open[i]);
        end
    end

    always_comb begin
        state_d  = state_q;
        gate_d   = gate_q;
        dly_d    = dly_q;
        wcfg_d   = wcfg_q;
        cnt_d    = cnt_q;
        wovf_d   = wovf_q;
        counts_d = counts_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (Start && (Gate_len != '0)) begin
                    state_d = S_ACQ;
                    gate_d  = Gate_len;
                    dly_d   = Delays;
                    wcfg_d  = Window;
                    cnt_d   = '0;
                    wovf_d  = '0;
                end
            end
            S_ACQ: begin
                if (Abort) begin
                    state_d = S_IDLE;
                end else begin
                    for (int k = 0; k < NPAIR; k++) begin
                        if (hit[k]) begin
                            if (cnt_q[k] == CMAX) wovf_d[k] = 1'b1;
                            else                  cnt_d[k]  = cnt_q[k] + CBITS'(1);
                        end
                    end
                    gate_d = gate_q - PBITS'(1);
                    if (gate_q == PBITS'(1)) begin
                        state_d  = S_HOLD;
                        counts_d = cnt_d;
                        ovf_d    = wovf_d;
                    end
                end
            end
            S_HOLD: begin
                if (Ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            gate_q   <= '0;
            dly_q    <= '0;
            wcfg_q   <= '0;
            cnt_q    <= '0;
            wovf_q   <= '0;
            counts_q <= '0;
            ovf_q    <= '0;
            prev_q   <= '0;
            for (int i = 0; i < NCHAN; i++) begin
                sr_q[i]  <= '0;
                win_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            gate_q   <= gate_d;
            dly_q    <= dly_d;
            wcfg_q   <= wcfg_d;
            cnt_q    <= cnt_d;
            wovf_q   <= wovf_d;
            counts_q <= counts_d;
            ovf_q    <= ovf_d;
            prev_q   <= Channels;
            for (int i = 0; i < NCHAN; i++) begin
                sr_q[i]  <= sr_d[i];
                win_q[i] <= win_d[i];
            end
        end
    end

    assign Busy   = (state_q != S_IDLE);
    assign Valid  = (state_q == S_HOLD);
    assign Counts = counts_q;
    assign Ovf    = ovf_q;

endmodule

// File: tb/tb_coincidence_counter.sv
// Directed bench: two instances (16-bit and 4-bit pair counters) share stimulus.
// Inputs driven and outputs sampled on the falling edge.
module tb_coincidence_counter;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [3:0]  Channels = '0;
    logic [15:0] Delays = '0;
    logic [2:0]  Window = '0;
    logic [23:0] Gate_len = '0;
    logic        Start = 1'b0;
    logic        Abort = 1'b0;
    logic        Ready = 1'b0;
    logic        Busy, Valid, Busy_s, Valid_s;
    logic [95:0] Counts;
    logic [23:0] Counts_s;
    logic [5:0]  Ovf, Ovf_s;

    int n_vec = 0;
    int n_bad = 0;
    int el = 0;

    always #5 Clk = ~Clk;

    coincidence_counter u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .Channels(Channels), .Delays(Delays),
        .Window(Window), .Gate_len(Gate_len), .Start(Start), .Abort(Abort),
        .Busy(Busy), .Valid(Valid), .Ready(Ready), .Counts(Counts), .Ovf(Ovf)
    );

    coincidence_counter #(.CBITS(4)) u_sat (
        .Clk(Clk), .Rst_n(Rst_n), .Channels(Channels), .Delays(Delays),
        .Window(Window), .Gate_len(Gate_len), .Start(Start), .Abort(Abort),
        .Busy(Busy_s), .Valid(Valid_s), .Ready(Ready), .Counts(Counts_s), .Ovf(Ovf_s)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
        el++;
    endtask

    task automatic pulse(input logic [3:0] m);
        Channels = m;
        tick();
        Channels = '0;
        tick();
    endtask

    task automatic pulse2(input logic [3:0] m1, input int gap, input logic [3:0] m2);
        Channels = m1;
        tick();
        Channels = '0;
        repeat (gap - 1) tick();
        Channels = m2;
        tick();
        Channels = '0;
        tick();
    endtask

    task automatic start_acq(input int g);
        Start    = 1'b1;
        Gate_len = 24'(g);
        el       = 0;
        tick();
        Start    = 1'b0;
    endtask

    task automatic run_to(input int n);
        while (el < n) tick();
    endtask

    task automatic wait_valid(input string tag, input int g);
        run_to(g);
        chk({tag, "_valid_early"}, Valid, 1'b0);
        tick();
        chk({tag, "_valid_at"}, Valid, 1'b1);
    endtask

    task automatic drain(input string tag);
        Ready = 1'b1;
        tick();
        Ready = 1'b0;
        chk({tag, "_valid_drop"}, Valid, 1'b0);
        chk({tag, "_busy_drop"}, Busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_valid", Valid, 1'b0);
        chk("rst_counts", Counts, '0);
        chk("rst_ovf", Ovf, '0);
        Rst_n = 1'b1;
        tick();

        // Same-cycle coincidences on (0,1), window 0
        start_acq(100);
        repeat (5) pulse(4'b0011);
        wait_valid("t1", 100);
        chk("t1_counts", Counts, 96'd5);
        chk("t1_ovf", Ovf, '0);
        drain("t1");

        // Window: ch2 three cycles after ch0
        Window = 3'd3;
        start_acq(20);
        pulse2(4'b0001, 3, 4'b0100);
        wait_valid("t2a", 20);
        chk("t2a_counts", Counts, 96'd1 << 16);
        drain("t2a");
        Window = 3'd2;
        start_acq(20);
        pulse2(4'b0001, 3, 4'b0100);
        wait_valid("t2b", 20);
        chk("t2b_counts", Counts, '0);
        drain("t2b");

        // Delay: ch1 delayed onto ch3 four cycles later
        Window = 3'd0;
        Delays = 16'h0040;
        start_acq(20);
        pulse2(4'b0010, 4, 4'b1000);
        wait_valid("t3a", 20);
        chk("t3a_counts", Counts, 96'd1 << 64);
        drain("t3a");
        Delays = 16'h0030;
        start_acq(20);
        pulse2(4'b0010, 4, 4'b1000);
        wait_valid("t3b", 20);
        chk("t3b_counts", Counts, '0);
        drain("t3b");

        // Saturation on the 4-bit instance
        Delays = '0;
        start_acq(60);
        repeat (20) pulse(4'b0011);
        wait_valid("t4", 60);
        chk("t4_counts16", Counts, 96'd20);
        chk("t4_ovf16", Ovf, '0);
        chk("t4_valid4", Valid_s, 1'b1);
        chk("t4_counts4", Counts_s, 96'hF);
        chk("t4_ovf4", Ovf_s, 96'b000001);
        drain("t4");

        // Abort in ACQ keeps the previous snapshot
        start_acq(100);
        repeat (3) pulse(4'b0011);
        run_to(10);
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        chk("t5_busy", Busy, 1'b0);
        chk("t5_valid", Valid, 1'b0);
        repeat (120) tick();
        chk("t5_valid_late", Valid, 1'b0);
        chk("t5_counts", Counts, 96'd20);
        chk("t5_ovf4", Ovf_s, 96'b000001);
        start_acq(0);
        chk("t5_gate0_busy", Busy, 1'b0);
        tick();
        chk("t5_gate0_busy2", Busy, 1'b0);

        // HOLD with Ready low: snapshot stable, Start ignored
        start_acq(10);
        repeat (2) pulse(4'b0011);
        wait_valid("t6", 10);
        Gate_len = 24'd5;
        for (int c = 0; c < 50; c++) begin
            Channels = c[0] ? 4'b1111 : 4'b0000;
            Start    = (c % 7 == 0);
            tick();
            if (c % 10 == 9) begin
                chk("t6_hold_counts", Counts, 96'd2);
                chk("t6_hold_valid", Valid, 1'b1);
            end
        end
        Channels = '0;
        Start    = 1'b0;
        drain("t6");

        // Reset during ACQ clears everything at once
        start_acq(100);
        repeat (2) pulse(4'b0011);
        run_to(20);
        Rst_n = 1'b0;
        #1;
        chk("t7_busy", Busy, 1'b0);
        chk("t7_valid", Valid, 1'b0);
        chk("t7_counts", Counts, '0);
        chk("t7_ovf", Ovf, '0);
        chk("t7_counts4", Counts_s, '0);
        tick();
        Rst_n = 1'b1;
        tick();
        chk("t7_busy_after", Busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
